// File: rtl/r_burst_buffer.sv
// rtl/r_burst_buffer.sv - Outgoing AXI R-beat buffer with cut-through or store-and-forward release
module r_burst_buffer #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int DEPTH      = 8,
  parameter int STORE_FWD  = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int ERR_CNT_W  = 16,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_in_valid,
  output logic                  r_in_ready,
  input  logic [ID_WIDTH-1:0]   r_in_id,
  input  logic [DATA_WIDTH-1:0] r_in_data,
  input  logic [RESP_WIDTH-1:0] r_in_resp,
  input  logic                  r_in_last,
  output logic                  r_out_valid,
  input  logic                  r_out_ready,
  output logic [ID_WIDTH-1:0]   r_out_id,
  output logic [DATA_WIDTH-1:0] r_out_data,
  output logic [RESP_WIDTH-1:0] r_out_resp,
  output logic                  r_out_last,
  output logic [CNT_W-1:0]      level,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      bursts_stored,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [ID_WIDTH-1:0]   head_id;
  logic [DATA_WIDTH-1:0] head_data;
  logic [RESP_WIDTH-1:0] head_resp;
  logic                  head_last;
  logic                  full, empty, push, pop, release_ok;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign {head_id, head_data, head_resp, head_last} = mem[rd_ptr];

  // Store-and-forward waits for a complete burst, but a full buffer must drain
  // anyway or a burst longer than DEPTH would never make progress.
  generate
    if (STORE_FWD != 0) begin : g_store_fwd
      assign release_ok = (bursts_stored != '0) | full;
    end else begin : g_cut_through
      assign release_ok = 1'b1;
    end
  endgenerate

  assign r_in_ready  = ~full;
  assign r_out_valid = ~empty & release_ok;
  assign push        = r_in_valid & r_in_ready;
  assign pop         = r_out_valid & r_out_ready;
  assign almost_full = (32'(level) >= AF_THRESH);

  assign r_out_id   = r_out_valid ? head_id   : '0;
  assign r_out_data = r_out_valid ? head_data : '0;
  assign r_out_resp = r_out_valid ? head_resp : '0;
  assign r_out_last = r_out_valid & head_last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {r_in_id, r_in_data, r_in_resp, r_in_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      bursts_stored <= '0;
      err_cnt       <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);

      if (push & ~pop)      level <= level + CNT_W'(1);
      else if (pop & ~push) level <= level - CNT_W'(1);

      if ((push & r_in_last) & ~(pop & head_last))      bursts_stored <= bursts_stored + CNT_W'(1);
      else if ((pop & head_last) & ~(push & r_in_last)) bursts_stored <= bursts_stored - CNT_W'(1);

      if (pop & head_resp[1] & (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_r_burst_buffer.sv
// tb/tb_r_burst_buffer.sv - Randomized queue-model bench for r_burst_buffer in both release modes
module tb_r_burst_buffer;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // cut-through instance, DEPTH=8
  logic        c_iv = 1'b0, c_or = 1'b0;
  beat_t       c_ib = '0;
  logic        c_ir, c_ov, c_af, c_olast;
  logic [7:0]  c_oid;
  logic [31:0] c_odata;
  logic [1:0]  c_oresp;
  logic [3:0]  c_level, c_bursts;
  logic [15:0] c_err;
  wire  [69:0] ct_got = {c_ir, c_ov, c_af, c_level, c_bursts, c_err, c_oid, c_odata, c_oresp, c_olast};

  r_burst_buffer #(.ID_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .r_in_valid(c_iv), .r_in_ready(c_ir), .r_in_id(c_ib.id), .r_in_data(c_ib.data),
    .r_in_resp(c_ib.resp), .r_in_last(c_ib.last),
    .r_out_valid(c_ov), .r_out_ready(c_or), .r_out_id(c_oid), .r_out_data(c_odata),
    .r_out_resp(c_oresp), .r_out_last(c_olast),
    .level(c_level), .almost_full(c_af), .bursts_stored(c_bursts), .err_cnt(c_err)
  );

  // store-and-forward instance, DEPTH=4, 2-bit error counter
  logic        s_iv = 1'b0, s_or = 1'b0;
  beat_t       s_ib = '0;
  logic        s_ir, s_ov, s_af, s_olast;
  logic [7:0]  s_oid;
  logic [31:0] s_odata;
  logic [1:0]  s_oresp;
  logic [2:0]  s_level, s_bursts;
  logic [1:0]  s_err;
  wire  [53:0] sf_got = {s_ir, s_ov, s_af, s_level, s_bursts, s_err, s_oid, s_odata, s_oresp, s_olast};

  r_burst_buffer #(.ID_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .STORE_FWD(1), .ERR_CNT_W(2)) u_sf (
    .clk(clk), .rst_n(rst_n),
    .r_in_valid(s_iv), .r_in_ready(s_ir), .r_in_id(s_ib.id), .r_in_data(s_ib.data),
    .r_in_resp(s_ib.resp), .r_in_last(s_ib.last),
    .r_out_valid(s_ov), .r_out_ready(s_or), .r_out_id(s_oid), .r_out_data(s_odata),
    .r_out_resp(s_oresp), .r_out_last(s_olast),
    .level(s_level), .almost_full(s_af), .bursts_stored(s_bursts), .err_cnt(s_err)
  );

  // Reference model: a queue of stored beats per instance plus an error tally.
  beat_t cq[$];
  beat_t sq[$];
  int    c_err_m = 0;
  int    s_err_m = 0;

  function automatic int ct_nlast();
    int n = 0;
    foreach (cq[i]) if (cq[i].last) n++;
    return n;
  endfunction

  function automatic int sf_nlast();
    int n = 0;
    foreach (sq[i]) if (sq[i].last) n++;
    return n;
  endfunction

  function automatic logic sf_valid_m();
    return (sq.size() > 0) && ((sf_nlast() > 0) || (sq.size() == 4));
  endfunction

  function automatic logic [69:0] ct_exp();
    beat_t h = '0;
    int    n = cq.size();
    if (n > 0) h = cq[0];
    return {n < 8, n > 0, n >= 6, 4'(n), 4'(ct_nlast()), 16'(c_err_m), h};
  endfunction

  function automatic logic [53:0] sf_exp();
    beat_t h = '0;
    int    n = sq.size();
    if (sf_valid_m()) h = sq[0];
    return {n < 4, sf_valid_m(), n >= 2, 3'(n), 3'(sf_nlast()), 2'(s_err_m), h};
  endfunction

  function automatic beat_t rand_beat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[42:0];
  endfunction

  task automatic ct_drive(input logic v, input beat_t b, input logic r);
    @(negedge clk);
    c_iv = v; c_ib = b; c_or = r;
    #1;
  endtask

  task automatic sf_drive(input logic v, input beat_t b, input logic r);
    @(negedge clk);
    s_iv = v; s_ib = b; s_or = r;
    #1;
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic ct_commit();
    logic pu, po;
    pu = c_iv && (cq.size() < 8);
    po = c_or && (cq.size() > 0);
    if (po) begin
      if (cq[0].resp[1] && c_err_m < 65535) c_err_m++;
      void'(cq.pop_front());
    end
    if (pu) cq.push_back(c_ib);
  endtask

  task automatic sf_commit();
    logic pu, po;
    pu = s_iv && (sq.size() < 4);
    po = s_or && sf_valid_m();
    if (po) begin
      if (sq[0].resp[1] && s_err_m < 3) s_err_m++;
      void'(sq.pop_front());
    end
    if (pu) sq.push_back(s_ib);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    c_iv = 1'b0; c_or = 1'b0; c_ib = '0;
    s_iv = 1'b0; s_or = 1'b0; s_ib = '0;
    cq.delete(); sq.delete();
    c_err_m = 0; s_err_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ct_got !== {1'b1, 69'd0}) begin
      n_fail++; $display("FAIL reset_ct: got %h expected %h", ct_got, {1'b1, 69'd0});
    end
    n_tests++;
    if (sf_got !== {1'b1, 53'd0}) begin
      n_fail++; $display("FAIL reset_sf: got %h expected %h", sf_got, {1'b1, 53'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cq.delete(); sq.delete(); c_err_m = 0; s_err_m = 0;
    for (int i = 0; i < 3; i++) begin
      ct_drive(1'b0, '0, 1'b1);
      n_tests++;
      if (ct_got !== ct_exp()) begin
        n_fail++; $display("FAIL reset_idle: got %h expected %h", ct_got, ct_exp());
      end
      ct_commit();
    end
  endtask

  task automatic test_ct_fill();
    int    acc = 0;
    beat_t b;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b = rand_beat();
      b.id = 8'(i);
      ct_drive(1'b1, b, 1'b0);
      n_tests++;
      if (ct_got !== ct_exp()) begin
        n_fail++; $display("FAIL ct_fill[%0d]: got %h expected %h", i, ct_got, ct_exp());
      end
      if (c_ir) acc++;
      ct_commit();
    end
    n_tests++;
    if (acc !== 8) begin
      n_fail++; $display("FAIL ct_fill_accepted: got %0d expected 8", acc);
    end
    for (int i = 0; i < 11; i++) begin
      ct_drive(1'b0, '0, 1'b1);
      n_tests++;
      if (ct_got !== ct_exp()) begin
        n_fail++; $display("FAIL ct_drain[%0d]: got %h expected %h", i, ct_got, ct_exp());
      end
      ct_commit();
    end
  endtask

  task automatic test_ct_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ct_drive(1'($urandom), rand_beat(), ($urandom_range(9, 0) < 6));
      n_tests++;
      if (ct_got !== ct_exp()) begin
        n_fail++; $display("FAIL ct_random[%0d]: got %h expected %h", i, ct_got, ct_exp());
      end
      ct_commit();
    end
  endtask

  task automatic test_sf_burst();
    beat_t b;
    int    nv = 0;
    int    first_valid = -1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = rand_beat();
      b.id = 8'(i);
      b.resp = 2'b00;
      b.last = (i == 2);
      sf_drive(i < 3, b, 1'b1);
      n_tests++;
      if (sf_got !== sf_exp()) begin
        n_fail++; $display("FAIL sf_burst[%0d]: got %h expected %h", i, sf_got, sf_exp());
      end
      if (s_ov) begin
        nv++;
        if (first_valid < 0) first_valid = i;
      end
      sf_commit();
    end
    n_tests++;
    if (nv !== 3 || first_valid !== 3) begin
      n_fail++; $display("FAIL sf_burst_release: got %0d beats from cycle %0d expected 3 from cycle 3", nv, first_valid);
    end
  endtask

  task automatic test_sf_overflow();
    beat_t b;
    beat_t sent[$];
    beat_t got[$];
    int    cyc = 0;
    do_reset();
    while (got.size() < 6 && cyc < 40) begin
      b = rand_beat();
      b.id = 8'(sent.size() + 16);
      b.last = (sent.size() == 5);
      sf_drive(sent.size() < 6, b, 1'b1);
      n_tests++;
      if (sf_got !== sf_exp()) begin
        n_fail++; $display("FAIL sf_overflow[%0d]: got %h expected %h", cyc, sf_got, sf_exp());
      end
      if (s_ov) got.push_back(beat_t'({s_oid, s_odata, s_oresp, s_olast}));
      if (s_iv && s_ir) sent.push_back(b);
      sf_commit();
      cyc++;
    end
    n_tests++;
    if (got.size() !== 6) begin
      n_fail++; $display("FAIL sf_overflow_count: got %0d beats expected 6 within 40 cycles", got.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_tests++;
      if (got[i] !== sent[i]) begin
        n_fail++; $display("FAIL sf_overflow_order[%0d]: got %h expected %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_err_count();
    logic [1:0] rs [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    beat_t      b;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b = rand_beat();
      b.resp = rs[i % 4];
      ct_drive(i < 4, b, i >= 4);
      ct_commit();
    end
    ct_drive(1'b0, '0, 1'b0);
    n_tests++;
    if (c_err !== 16'd2) begin
      n_fail++; $display("FAIL err_ct: got %0d expected 2", c_err);
    end
    do_reset();
    for (int i = 0; i < 13; i++) begin
      b = rand_beat();
      b.last = 1'b1;
      b.resp = (i < 4) ? rs[i] : 2'b10;
      sf_drive(i < 9, b, 1'b1);
      n_tests++;
      if (sf_got !== sf_exp()) begin
        n_fail++; $display("FAIL err_sf[%0d]: got %h expected %h", i, sf_got, sf_exp());
      end
      sf_commit();
    end
    n_tests++;
    if (s_err !== 2'd3) begin
      n_fail++; $display("FAIL err_sat: got %0d expected 3", s_err);
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ct_drive(1'b1, rand_beat(), 1'b0);
      ct_commit();
    end
    for (int i = 0; i < 20; i++) begin
      ct_drive(1'b1, rand_beat(), 1'b1);
      n_tests++;
      if (ct_got !== ct_exp() || c_level !== 4'd3) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", i, ct_got, ct_exp());
      end
      ct_commit();
    end
    ct_drive(1'b1, rand_beat(), 1'b1);
    #2 rst_n = 1'b0;
    cq.delete(); c_err_m = 0;
    #1;
    n_tests++;
    if (ct_got !== ct_exp()) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", ct_got, ct_exp());
    end
    @(negedge clk);
    c_iv = 1'b0; c_or = 1'b0;
    rst_n = 1'b1;
    ct_drive(1'b0, '0, 1'b1);
    n_tests++;
    if (ct_got !== ct_exp()) begin
      n_fail++; $display("FAIL after_reset: got %h expected %h", ct_got, ct_exp());
    end
  endtask

  initial begin
    test_reset();
    test_ct_fill();
    test_ct_random();
    test_sf_burst();
    test_sf_overflow();
    test_err_count();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
